// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave serial front end.
// Deserialises MOSI command words, serialises RAM read data on MISO.
module spi_slave_if #(
  parameter int DIN_WIDTH  = 10,
  parameter int DOUT_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  rx_valid,
  output logic [DIN_WIDTH-1:0]  rx_data,
  input  logic                  tx_valid,
  input  logic [DOUT_WIDTH-1:0] tx_data
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    SEND      = 3'd5,
    DONE      = 3'd6
  } state_t;

  localparam logic [CNT_WIDTH-1:0] RX_LAST =
    CNT_WIDTH'(DIN_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] TX_LAST =
    CNT_WIDTH'(DOUT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);

  state_t                state_q;
  state_t                state_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [DIN_WIDTH-1:0]  sh_q;
  logic [DIN_WIDTH-1:0]  sh_d;
  logic [DIN_WIDTH-1:0]  sh_in;
  logic [DOUT_WIDTH-1:0] tx_q;
  logic [DOUT_WIDTH-1:0] tx_d;
  logic                  rd_addr_seen;
  logic                  rd_addr_seen_d;
  logic                  rx_valid_d;
  logic [DIN_WIDTH-1:0]  rx_data_d;
  logic                  miso_d;
  logic                  rx_last;
  logic                  tx_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      tx_q         <= '0;
      rd_addr_seen <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      miso         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      tx_q         <= tx_d;
      rd_addr_seen <= rd_addr_seen_d;
      rx_valid     <= rx_valid_d;
      rx_data      <= rx_data_d;
      miso         <= miso_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sh_d           = sh_q;
    tx_d           = tx_q;
    rd_addr_seen_d = rd_addr_seen;
    rx_valid_d     = 1'b0;
    rx_data_d      = rx_data;
    miso_d         = miso;
    sh_in          = {sh_q[DIN_WIDTH-2:0], mosi};
    rx_last        = (cnt_q == RX_LAST);
    tx_last        = (cnt_q == TX_LAST);
    if (ss_n) begin
      state_d = IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = CHK_CMD;
        CHK_CMD: begin
          if (!mosi)
            state_d = WRITE;
          else if (rd_addr_seen)
            state_d = READ_DATA;
          else
            state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          sh_d = sh_in;
          if (rx_last) begin
            rx_valid_d = 1'b1;
            rx_data_d  = sh_in;
            cnt_d      = '0;
            if (state_q == READ_DATA)
              state_d = SEND;
            else
              state_d = DONE;
            if (state_q == READ_ADD)
              rd_addr_seen_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        SEND: begin
          // cnt 0 = waiting for RAM, 1..N = bits already on miso
          if (cnt_q == '0) begin
            if (tx_valid) begin
              miso_d = tx_data[DOUT_WIDTH-1];
              tx_d   = {tx_data[DOUT_WIDTH-2:0], 1'b0};
              cnt_d  = ONE;
            end
          end else if (tx_last) begin
            miso_d         = 1'b0;
            rd_addr_seen_d = 1'b0;
            cnt_d          = '0;
            state_d        = DONE;
          end else begin
            miso_d = tx_q[DOUT_WIDTH-1];
            tx_d   = {tx_q[DOUT_WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + ONE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: scenario bench for the SPI slave front end.
// Expected words/bits are queued at drive time, popped on DUT output.
module tb_spi_slave_if;

  localparam int DW = 10;
  localparam int OW = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_RADD  = 3'd3;
  localparam logic [2:0] S_RDAT  = 3'd4;
  localparam logic [2:0] S_SEND  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ss_n = 1'b1;
  logic          mosi = 1'b0;
  logic          miso;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          tx_valid = 1'b0;
  logic [OW-1:0] tx_data = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulse  = 0;
  int p0;
  logic          miso_hi = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  logic          bit_q[$];
  logic [DW-1:0] got;
  logic [DW-1:0] exp_w;
  logic          exp_b;

  always #5 clk = ~clk;

  spi_slave_if dut (
    .clk      (clk),
    .rst      (rst),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_data  (tx_data)
  );

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_pulse++;
      obs_q.push_back(rx_data);
    end
    if (miso !== 1'b0) miso_hi = 1'b1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame(input logic cmd);
    ss_n = 1'b0;
    mosi = 1'b0;
    tick();
    mosi = cmd;
    tick();
  endtask

  task automatic shift(input logic [DW-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = w[DW-1-i];
      tick();
    end
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    mosi = 1'b0;
    tick();
  endtask

  task automatic pop_word();
    got   = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", rx_valid); end
    n_checks++;
    if (rx_data !== '0) begin n_fail++; $display("FAIL rst_data got %h exp 000", rx_data); end
    n_checks++;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL rst_miso got %b exp 0", miso); end
    n_checks++;
    if (dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL rst_state got %0d exp %0d", dut.state_q, S_IDLE); end
    n_checks++;
    if (dut.rd_addr_seen !== 1'b0) begin n_fail++; $display("FAIL rst_seen got %b exp 0", dut.rd_addr_seen); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_addr();
    p0 = n_pulse;
    exp_q.push_back(10'h005);
    start_frame(1'b0);
    n_checks++;
    if (dut.state_q !== S_WRITE) begin n_fail++; $display("FAIL wa_state got %0d exp %0d", dut.state_q, S_WRITE); end
    shift(10'h005, 10);
    n_checks++;
    if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL wa_valid got %b exp 1", rx_valid); end
    n_checks++;
    if (dut.state_q !== S_DONE) begin n_fail++; $display("FAIL wa_done got %0d exp %0d", dut.state_q, S_DONE); end
    mosi = 1'b1;
    tick();
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL wa_pulse got %b exp 0", rx_valid); end
    n_checks++;
    if (dut.state_q !== S_DONE) begin n_fail++; $display("FAIL wa_hold got %0d exp %0d", dut.state_q, S_DONE); end
    end_frame();
    n_checks++;
    if (dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL wa_idle got %0d exp %0d", dut.state_q, S_IDLE); end
    n_checks++;
    if (n_pulse - p0 !== 1) begin n_fail++; $display("FAIL wa_npulse got %0d exp 1", n_pulse - p0); end
    pop_word();
    n_checks++;
    if (got !== exp_w) begin n_fail++; $display("FAIL wa_data got %h exp %h", got, exp_w); end
  endtask

  task automatic test_write_data();
    p0 = n_pulse;
    miso_hi = 1'b0;
    exp_q.push_back(10'h1A5);
    start_frame(1'b0);
    shift(10'h1A5, 10);
    n_checks++;
    if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL wd_valid got %b exp 1", rx_valid); end
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick();
    end_frame();
    n_checks++;
    if (n_pulse - p0 !== 1) begin n_fail++; $display("FAIL wd_npulse got %0d exp 1", n_pulse - p0); end
    pop_word();
    n_checks++;
    if (got !== exp_w) begin n_fail++; $display("FAIL wd_data got %h exp %h", got, exp_w); end
    n_checks++;
    if (miso_hi !== 1'b0) begin n_fail++; $display("FAIL wd_miso got %b exp 0", miso_hi); end
  endtask

  task automatic test_read_addr();
    p0 = n_pulse;
    exp_q.push_back(10'h205);
    start_frame(1'b1);
    n_checks++;
    if (dut.state_q !== S_RADD) begin n_fail++; $display("FAIL ra_state got %0d exp %0d", dut.state_q, S_RADD); end
    shift(10'h205, 10);
    n_checks++;
    if (dut.rd_addr_seen !== 1'b1) begin n_fail++; $display("FAIL ra_seen got %b exp 1", dut.rd_addr_seen); end
    tick();
    end_frame();
    n_checks++;
    if (n_pulse - p0 !== 1) begin n_fail++; $display("FAIL ra_npulse got %0d exp 1", n_pulse - p0); end
    pop_word();
    n_checks++;
    if (got !== exp_w) begin n_fail++; $display("FAIL ra_data got %h exp %h", got, exp_w); end
  endtask

  task automatic test_read_data();
    logic [OW-1:0] rd;
    rd = 8'hA5;
    p0 = n_pulse;
    exp_q.push_back(10'h3C3);
    start_frame(1'b1);
    n_checks++;
    if (dut.state_q !== S_RDAT) begin n_fail++; $display("FAIL rd_state got %0d exp %0d", dut.state_q, S_RDAT); end
    shift(10'h3C3, 10);
    n_checks++;
    if (dut.state_q !== S_SEND) begin n_fail++; $display("FAIL rd_send got %0d exp %0d", dut.state_q, S_SEND); end
    tick();
    for (int b = OW - 1; b >= 0; b--) bit_q.push_back(rd[b]);
    bit_q.push_back(1'b0);
    tx_valid = 1'b1;
    tx_data  = rd;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < OW + 1; i++) begin
      if (i > 0) begin
        mosi = 1'($urandom_range(0, 1));
        tick();
      end
      exp_b = bit_q.pop_front();
      n_checks++;
      if (miso !== exp_b) begin n_fail++; $display("FAIL rd_miso%0d got %b exp %b", i, miso, exp_b); end
    end
    n_checks++;
    if (dut.state_q !== S_DONE) begin n_fail++; $display("FAIL rd_done got %0d exp %0d", dut.state_q, S_DONE); end
    n_checks++;
    if (dut.rd_addr_seen !== 1'b0) begin n_fail++; $display("FAIL rd_seen got %b exp 0", dut.rd_addr_seen); end
    end_frame();
    n_checks++;
    if (n_pulse - p0 !== 1) begin n_fail++; $display("FAIL rd_npulse got %0d exp 1", n_pulse - p0); end
    pop_word();
    n_checks++;
    if (got !== exp_w) begin n_fail++; $display("FAIL rd_data got %h exp %h", got, exp_w); end
  endtask

  task automatic test_back_to_back();
    p0 = n_pulse;
    exp_q.push_back(10'h2AA);
    exp_q.push_back(10'h155);
    start_frame(1'b0);
    shift(10'h2AA, 10);
    end_frame();
    start_frame(1'b0);
    shift(10'h155, 10);
    end_frame();
    n_checks++;
    if (n_pulse - p0 !== 2) begin n_fail++; $display("FAIL b2b_npulse got %0d exp 2", n_pulse - p0); end
    for (int i = 0; i < 2; i++) begin
      pop_word();
      n_checks++;
      if (got !== exp_w) begin n_fail++; $display("FAIL b2b_data%0d got %h exp %h", i, got, exp_w); end
    end
  endtask

  task automatic test_abort();
    p0 = n_pulse;
    start_frame(1'b0);
    shift(10'h3FF, 5);
    end_frame();
    n_checks++;
    if (dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL ab_idle got %0d exp %0d", dut.state_q, S_IDLE); end
    n_checks++;
    if (dut.cnt_q !== '0) begin n_fail++; $display("FAIL ab_cnt got %0d exp 0", dut.cnt_q); end
    tick();
    n_checks++;
    if (n_pulse - p0 !== 0) begin n_fail++; $display("FAIL ab_npulse got %0d exp 0", n_pulse - p0); end
    exp_q.push_back(10'h0F0);
    start_frame(1'b0);
    shift(10'h0F0, 10);
    end_frame();
    pop_word();
    n_checks++;
    if (got !== exp_w) begin n_fail++; $display("FAIL ab_clean got %h exp %h", got, exp_w); end
    // truncated read: address seen survives the abort
    exp_q.push_back(10'h2AB);
    start_frame(1'b1);
    shift(10'h2AB, 10);
    end_frame();
    pop_word();
    n_checks++;
    if (got !== exp_w) begin n_fail++; $display("FAIL ab_radd got %h exp %h", got, exp_w); end
    exp_q.push_back(10'h300);
    start_frame(1'b1);
    shift(10'h300, 10);
    tick();
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    end_frame();
    n_checks++;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL ab_miso got %b exp 0", miso); end
    n_checks++;
    if (dut.rd_addr_seen !== 1'b1) begin n_fail++; $display("FAIL ab_seen got %b exp 1", dut.rd_addr_seen); end
    pop_word();
    n_checks++;
    if (got !== exp_w) begin n_fail++; $display("FAIL ab_rdat got %h exp %h", got, exp_w); end
    start_frame(1'b1);
    n_checks++;
    if (dut.state_q !== S_RDAT) begin n_fail++; $display("FAIL ab_next got %0d exp %0d", dut.state_q, S_RDAT); end
    end_frame();
  endtask

  task automatic test_async_reset();
    exp_q.push_back(10'h3AA);
    start_frame(1'b1);
    shift(10'h3AA, 10);
    tick();
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick();
    n_checks++;
    if (miso !== 1'b1) begin n_fail++; $display("FAIL ar_pre got %b exp 1", miso); end
    pop_word();
    n_checks++;
    if (got !== exp_w) begin n_fail++; $display("FAIL ar_data got %h exp %h", got, exp_w); end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (miso !== 1'b0) begin n_fail++; $display("FAIL ar_miso got %b exp 0", miso); end
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got %b exp 0", rx_valid); end
    n_checks++;
    if (dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL ar_state got %0d exp %0d", dut.state_q, S_IDLE); end
    n_checks++;
    if (dut.rd_addr_seen !== 1'b0) begin n_fail++; $display("FAIL ar_seen got %b exp 0", dut.rd_addr_seen); end
    tick();
    rst = 1'b0;
    end_frame();
    start_frame(1'b1);
    n_checks++;
    if (dut.state_q !== S_RADD) begin n_fail++; $display("FAIL ar_next got %0d exp %0d", dut.state_q, S_RADD); end
    end_frame();
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_write_data();
    test_read_addr();
    test_read_data();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- Serial front end of the SPI slave. Deserialises MOSI frames into 10-bit command words (2 control bits + 8 data/address bits) and pulses rx_valid to the downstream RAM.
- Captures the RAM's tx_valid/dout read response and shifts it out on MISO.
- clk is the SPI serial clock. MOSI is sampled and MISO is updated on the rising edge of clk.

Parameters:
- DIN_WIDTH, 10, width of the command word sent to the RAM (bits [9:8] control, [7:0] payload)
- DOUT_WIDTH, 8, width of the read data returned by the RAM
- CNT_WIDTH, 4, bit counter width; must satisfy 2^CNT_WIDTH > DIN_WIDTH

Ports:
- clk  in  1  serial clock; all flops on the rising edge
- rst  in  1  one clock; reset is asynchronous and active-high
- ss_n  in  1  slave select, active-low; frame boundary
- mosi  in  1  serial data in, MSB first
- miso  out  1  serial data out, MSB first
- rx_valid  out  1  one-cycle pulse; rx_data valid
- rx_data  out  DIN_WIDTH  assembled command word to the RAM
- tx_valid  in  1  RAM read data valid (single-cycle)
- tx_data  in  DOUT_WIDTH  RAM read data

Behaviour:
- Reset values (rst=1, async):
  - state=IDLE, counter=0, shift register=0, rd_addr_seen=0
  - rx_valid=0, rx_data=0, miso=0
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, SEND, DONE.
- ss_n=1 in any state forces state to IDLE on the next edge, with counter=0 and rx_valid=0. rd_addr_seen is kept. miso<=0.
- IDLE:
  - ss_n=0 -> CHK_CMD.
- CHK_CMD: samples mosi as the command bit only; the bit is not stored.
  - 0 -> WRITE.
  - 1 and rd_addr_seen=0 -> READ_ADD.
  - 1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift mosi into the shift register, MSB first, for exactly DIN_WIDTH edges; the counter runs 0..DIN_WIDTH-1.
- Frame completion, at the edge sampling the DIN_WIDTH-th bit:
  - rx_data <= full word; rx_valid <= 1 for exactly one cycle.
  - Counter clears.
  - From WRITE -> DONE.
  - From READ_ADD -> DONE, and rd_addr_seen <= 1.
  - From READ_DATA -> SEND.
- The control bits in rx_data[9:8] are passed through unmodified. The block does not check them against the state; the RAM decodes them.
- SEND:
  - Waits for tx_valid=1. Extra mosi bits are ignored.
  - At the edge where tx_valid=1: latch tx_data, miso <= tx_data[7], counter=1.
  - Each following edge drives the next lower bit. After tx_data[0] has been driven for one cycle: miso <= 0, rd_addr_seen <= 0, state -> DONE.
  - tx_valid asserted outside SEND is ignored.
- DONE:
  - Holds, ignoring mosi, until ss_n=1 returns the block to IDLE.
- Latency:
  - rx_valid is high in the cycle after the last command bit is sampled.
  - The RAM responds one cycle later.
  - miso carries the MSB in the cycle after tx_valid.
- Aborted frames:
  - ss_n rising mid-shift discards the partial word; no rx_valid.
  - ss_n rising mid-SEND truncates the output. rd_addr_seen stays 1, so the next read command goes to READ_DATA.
- Reset mid-frame clears everything immediately, including rd_addr_seen.
- Only one rx_valid pulse per frame.

Test Plan:
- Write address: rst pulse; ss_n=0; mosi 0 then 00_0000_0101 -> one rx_valid with rx_data=10'h005 after the 10th bit; state DONE; ss_n=1 -> IDLE.
- Write data: frame mosi 0 then 01_1010_0101 -> rx_data=10'h1A5, single-cycle rx_valid; no miso activity (miso=0 throughout).
- Read address: frame mosi 1 then 10_0000_0101 -> rx_data=10'h205; rd_addr_seen=1.
- Read data: next frame mosi 1 then 11_xxxx_xxxx; tx_valid=1 with tx_data=8'hA5 one cycle after rx_valid -> miso=1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0; rd_addr_seen=0.
- Abort: ss_n rises after 5 shifted bits -> no rx_valid; next frame decodes cleanly.
- Async reset asserted mid-SEND between edges -> miso=0, rx_valid=0, state IDLE without a clock edge; a following read command goes to READ_ADD.
